// File: rtl/exec_wb_stage.sv
// Execute/write-back stage: ALU with iterative 1-bit/cycle shifter driving the register-file write port.
// Optional build macro EXEC_FORWARD_EN: forward write_data into the operands instead of interlocking.
module exec_wb_stage #(
  parameter int W  = 8,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [W-1:0]  opA,
  input  logic [W-1:0]  opB,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  input  logic [DW-1:0] dest,
  input  logic          wr_en_in,
  output logic          RegWrite,
  output logic [DW-1:0] destination,
  output logic [W-1:0]  write_data,
  output logic          flag_zero,
  output logic          flag_carry,
  output logic          busy
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_CMP  = 3'b111;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q;
  logic [2:0]    cnt_q;
  logic          dir_q;
  logic [DW-1:0] pdest_q;
  logic          pwr_q;
  logic          regwrite_q;
  logic [DW-1:0] destination_q;
  logic [W-1:0]  write_data_q;
  logic          zero_q, carry_q;

  logic [W-1:0]  a_eff, b_eff;
  logic          hazard;

`ifdef EXEC_FORWARD_EN
  // The register file is one write behind; bypass the value it is about to store.
  assign a_eff  = (regwrite_q && (src_a == destination_q)) ? write_data_q : opA;
  assign b_eff  = (regwrite_q && (src_b == destination_q)) ? write_data_q : opB;
  assign hazard = 1'b0;
`else
  assign a_eff  = opA;
  assign b_eff  = opB;
  assign hazard = regwrite_q && ((src_a == destination_q) || (src_b == destination_q));
`endif

  logic          accept;
  logic [2:0]    shamt;
  logic          is_shift;
  logic          start_shift;
  logic          shift_done;
  logic [W:0]    sum;
  logic [W-1:0]  diff;
  logic [W-1:0]  alu_res;
  logic          alu_c;
  logic [W-1:0]  acc_nxt;
  logic          out_bit;

  assign accept      = in_valid && in_ready;
  assign shamt       = b_eff[2:0];
  assign is_shift    = (op == OP_SHL) || (op == OP_SHR);
  assign start_shift = accept && is_shift && (shamt != 3'd0);
  assign shift_done  = (state_q == S_SHIFT) && (cnt_q == 3'd1);

  always_comb begin
    sum     = {1'b0, a_eff} + {1'b0, b_eff};
    diff    = a_eff - b_eff;
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD:         begin alu_res = sum[W-1:0]; alu_c = sum[W]; end
      OP_SUB, OP_CMP: begin alu_res = diff; alu_c = (a_eff >= b_eff); end
      OP_AND:         alu_res = a_eff & b_eff;
      OP_XOR:         alu_res = a_eff ^ b_eff;
      OP_SHL, OP_SHR: alu_res = a_eff;  // only reached directly for a zero shift amount
      OP_PASS:        alu_res = b_eff;
      default:        alu_res = '0;
    endcase
  end

  // dir_q = 1 selects a right shift
  assign acc_nxt = dir_q ? (acc_q >> 1) : (acc_q << 1);
  assign out_bit = dir_q ? acc_q[0] : acc_q[W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_shift) state_d = S_SHIFT;
      S_SHIFT: if (shift_done)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE) && !hazard;
    busy     = (state_q == S_SHIFT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q         <= '0;
      cnt_q         <= '0;
      dir_q         <= 1'b0;
      pdest_q       <= '0;
      pwr_q         <= 1'b0;
      regwrite_q    <= 1'b0;
      destination_q <= '0;
      write_data_q  <= '0;
      zero_q        <= 1'b0;
      carry_q       <= 1'b0;
    end else begin
      if (start_shift) begin
        acc_q   <= a_eff;
        cnt_q   <= shamt;
        dir_q   <= (op == OP_SHR);
        pdest_q <= dest;
        pwr_q   <= wr_en_in;
      end else if (state_q == S_SHIFT) begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_q - 3'd1;
      end

      regwrite_q <= 1'b0;
      if (accept && !start_shift) begin
        regwrite_q    <= wr_en_in && (op != OP_CMP);
        destination_q <= dest;
        write_data_q  <= alu_res;
        zero_q        <= (alu_res == '0);
        carry_q       <= alu_c;
      end else if (shift_done) begin
        regwrite_q    <= pwr_q;
        destination_q <= pdest_q;
        write_data_q  <= acc_nxt;
        zero_q        <= (acc_nxt == '0);
        carry_q       <= out_bit;
      end
    end
  end

  assign RegWrite    = regwrite_q;
  assign destination = destination_q;
  assign write_data  = write_data_q;
  assign flag_zero   = zero_q;
  assign flag_carry  = carry_q;

endmodule
